// File: rtl/vector_control_sequencer.sv
// Multi-beat LEGv8 main control sequencer: decodes the opcode of an accepted instruction
// and presents a registered control word for one beat per vector lane or MUL cycle.
module vector_control_sequencer #(
  parameter int INSTR_W    = 32,
  parameter int LANES      = 4,
  parameter int MUL_CYCLES = 3,
  localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instruction,
  output logic               instr_ready,
  input  logic               flush,
  output logic               ctl_valid,
  output logic [1:0]         control_aluop,
  output logic               control_alusrc,
  output logic               control_isZeroBranch,
  output logic               control_isUnconBranch,
  output logic               control_memRead,
  output logic               control_memwrite,
  output logic               control_regwrite,
  output logic               control_mem2reg,
  output logic [LANE_W-1:0]  lane_idx,
  output logic               lane_last,
  output logic               illegal
);

  localparam int REM_MAX = (LANES > MUL_CYCLES) ? LANES : MUL_CYCLES;
  localparam int REM_W   = $clog2(REM_MAX + 1);
  localparam logic [REM_W-1:0] VEC_LAST = REM_W'(LANES - 1);
  localparam logic [REM_W-1:0] MUL_LAST = REM_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_VEC, S_MULW} state_t;
  typedef enum logic [1:0] {K_SINGLE, K_VEC, K_MUL} kind_t;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       zero_branch;
    logic       uncon_branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem2reg;
    logic       illegal;
    logic       is_mul;    // regwrite is deferred to the final beat
  } ctl_t;

  typedef struct packed {
    kind_t kind;
    ctl_t  ctl;
  } dec_t;

  function automatic dec_t decode(input logic [10:0] op);
    dec_t d;
    d = '0;
    d.kind = K_SINGLE;
    if (op[10:5] == 6'b000101) begin
      d.ctl.aluop = 2'b01; d.ctl.uncon_branch = 1'b1;
    end else if (op[10:3] == 8'b10110100) begin
      d.ctl.aluop = 2'b01; d.ctl.zero_branch = 1'b1;
    end else begin
      case (op)
        11'b11111000010: begin
          d.ctl.alusrc = 1'b1; d.ctl.mem_read = 1'b1; d.ctl.mem2reg = 1'b1; d.ctl.reg_write = 1'b1;
        end
        11'b11111000000: begin
          d.ctl.alusrc = 1'b1; d.ctl.mem_write = 1'b1;
        end
        11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
          d.ctl.aluop = 2'b10; d.ctl.reg_write = 1'b1;
        end
        11'b10011011000: begin
          d.kind = K_MUL; d.ctl.aluop = 2'b10; d.ctl.is_mul = 1'b1;
        end
        11'b10001011100, 11'b11001011100, 11'b10011011100: begin
          d.kind = K_VEC; d.ctl.aluop = 2'b10; d.ctl.reg_write = 1'b1;
        end
        11'b10101011100: begin
          d.kind = K_VEC; d.ctl.aluop = 2'b10; d.ctl.alusrc = 1'b1; d.ctl.reg_write = 1'b1;
        end
        11'b11111011100: begin
          d.kind = K_VEC; d.ctl.aluop = 2'b10; d.ctl.alusrc = 1'b1; d.ctl.mem_write = 1'b1;
        end
        11'b11111011110: begin
          d.kind = K_VEC; d.ctl.aluop = 2'b10; d.ctl.alusrc = 1'b1; d.ctl.mem_read = 1'b1;
          d.ctl.mem2reg = 1'b1; d.ctl.reg_write = 1'b1;
        end
        default: d.ctl.illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

  state_t            state_q, state_d;
  logic [REM_W-1:0]  rem_q, rem_d, n_last;
  logic [LANE_W-1:0] lane_q, lane_d;
  ctl_t              ctl_q, ctl_d;
  dec_t              dec;
  logic              accept;

  // Only the opcode field is decoded; the operand bits pass to the datapath elsewhere.
  if (INSTR_W > 11) begin : g_operands
    logic unused_operand_bits;
    assign unused_operand_bits = ^instruction[INSTR_W-12:0];
  end

  assign instr_ready = (rem_q == '0) && !flush;
  assign accept      = instr_valid && instr_ready;
  assign dec         = decode(instruction[INSTR_W-1 -: 11]);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    rem_d   = rem_q;
    lane_d  = lane_q;
    ctl_d   = ctl_q;
    n_last  = '0;
    case (dec.kind)
      K_VEC:   n_last = VEC_LAST;
      K_MUL:   n_last = MUL_LAST;
      default: n_last = '0;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      rem_d   = '0;
      lane_d  = '0;
      ctl_d   = '0;
    end else if (accept) begin
      ctl_d  = dec.ctl;
      lane_d = '0;
      rem_d  = n_last;
      if (n_last == '0)          state_d = S_ISSUE;
      else if (dec.kind == K_VEC) state_d = S_VEC;
      else                        state_d = S_MULW;
    end else if (rem_q != '0) begin
      rem_d = rem_q - REM_W'(1);
      if (state_q == S_VEC) lane_d = lane_q + LANE_W'(1);
    end else begin
      state_d = S_IDLE;
      lane_d  = '0;
      ctl_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      lane_q  <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
      ctl_q   <= ctl_d;
    end
  end

  // The control register is cleared whenever the block idles, so outputs read 0 there.
  assign ctl_valid             = (state_q != S_IDLE);
  assign control_aluop         = ctl_q.aluop;
  assign control_alusrc        = ctl_q.alusrc;
  assign control_isZeroBranch  = ctl_q.zero_branch;
  assign control_isUnconBranch = ctl_q.uncon_branch;
  assign control_memRead       = ctl_q.mem_read;
  assign control_memwrite      = ctl_q.mem_write;
  assign control_regwrite      = ctl_q.reg_write || (ctl_q.is_mul && rem_q == '0);
  assign control_mem2reg       = ctl_q.mem2reg;
  assign lane_idx              = lane_q;
  assign lane_last             = ctl_valid && (rem_q == '0);
  assign illegal               = ctl_q.illegal;

endmodule

// File: tb/tb_vector_control_sequencer.sv
// Bench for vector_control_sequencer: directed cycle table, async reset sequence,
// and random traffic scored against a queue-of-beats reference model.
module tb_vector_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        instr_ready;
  logic        flush;
  logic        ctl_valid;
  logic [1:0]  control_aluop;
  logic        control_alusrc, control_isZeroBranch, control_isUnconBranch;
  logic        control_memRead, control_memwrite, control_regwrite, control_mem2reg;
  logic [1:0]  lane_idx;
  logic        lane_last;
  logic        illegal;

  int tests  = 0;
  int failed = 0;

  vector_control_sequencer #(.INSTR_W(32), .LANES(4), .MUL_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .instr_ready(instr_ready), .flush(flush), .ctl_valid(ctl_valid),
    .control_aluop(control_aluop), .control_alusrc(control_alusrc),
    .control_isZeroBranch(control_isZeroBranch), .control_isUnconBranch(control_isUnconBranch),
    .control_memRead(control_memRead), .control_memwrite(control_memwrite),
    .control_regwrite(control_regwrite), .control_mem2reg(control_mem2reg),
    .lane_idx(lane_idx), .lane_last(lane_last), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Observation word: {ctl_valid, instr_ready, aluop[1:0], alusrc, zbr, ubr, memRead,
  //                    memwrite, regwrite, mem2reg, lane_idx[1:0], lane_last, illegal}
  localparam logic [10:0] OP_ADD  = 11'b10001011000, OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000, OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_MUL  = 11'b10011011000;
  localparam logic [10:0] OP_VADD = 11'b10001011100, OP_VSUB = 11'b11001011100;
  localparam logic [10:0] OP_VMUL = 11'b10011011100, OP_VMOV = 11'b10101011100;
  localparam logic [10:0] OP_VST1 = 11'b11111011100, OP_VLD1 = 11'b11111011110;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101, OP_B    = 11'b00010111011;

  //                               aluop src zb ub mr mw rw m2r
  localparam logic [8:0] C_NONE = 9'b00_0_0_0_0_0_0_0;
  localparam logic [8:0] C_ALU  = 9'b10_0_0_0_0_0_1_0;
  localparam logic [8:0] C_MULW = 9'b10_0_0_0_0_0_0_0;
  localparam logic [8:0] C_VLD1 = 9'b10_1_0_0_1_0_1_1;
  localparam logic [8:0] C_CBZ  = 9'b01_0_1_0_0_0_0_0;

  function automatic logic [14:0] e(input logic v, input logic rdy, input logic [8:0] c,
                                    input logic [1:0] ln, input logic last, input logic ill);
    return {v, rdy, c, ln, last, ill};
  endfunction

  function automatic logic [14:0] observe();
    return {ctl_valid, instr_ready, control_aluop, control_alusrc, control_isZeroBranch,
            control_isUnconBranch, control_memRead, control_memwrite, control_regwrite,
            control_mem2reg, lane_idx, lane_last, illegal};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference model: what the ISA says each opcode means, expanded into a list of beats.
  typedef struct {
    logic [8:0] ctl;
    int         beats;
    logic       vec;
    logic       mul;
    logic       ill;
  } ref_t;

  function automatic ref_t ref_decode(input logic [10:0] op);
    ref_t r;
    r = '{ctl: C_NONE, beats: 1, vec: 1'b0, mul: 1'b0, ill: 1'b0};
    if (op[10:5] == 6'b000101)        r.ctl = 9'b01_0_0_1_0_0_0_0;
    else if (op[10:3] == 8'b10110100) r.ctl = C_CBZ;
    else if (op == OP_LDUR)           r.ctl = 9'b00_1_0_0_1_0_1_1;
    else if (op == OP_STUR)           r.ctl = 9'b00_1_0_0_0_1_0_0;
    else if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) r.ctl = C_ALU;
    else if (op == OP_MUL) begin r.ctl = C_MULW; r.beats = 3; r.mul = 1'b1; end
    else if (op == OP_VADD || op == OP_VSUB || op == OP_VMUL) begin
      r.ctl = C_ALU; r.beats = 4; r.vec = 1'b1;
    end
    else if (op == OP_VMOV) begin r.ctl = 9'b10_1_0_0_0_0_1_0; r.beats = 4; r.vec = 1'b1; end
    else if (op == OP_VST1) begin r.ctl = 9'b10_1_0_0_0_1_0_0; r.beats = 4; r.vec = 1'b1; end
    else if (op == OP_VLD1) begin r.ctl = C_VLD1; r.beats = 4; r.vec = 1'b1; end
    else r.ill = 1'b1;
    return r;
  endfunction

  logic [14:0] beat_q[$];

  task automatic push_beats(input logic [10:0] op);
    ref_t r;
    logic [8:0] c;
    r = ref_decode(op);
    for (int i = 0; i < r.beats; i++) begin
      c = r.ctl;
      if (r.mul && i == r.beats - 1) c[1] = 1'b1;  // regwrite on the product beat
      beat_q.push_back(e(1'b1, 1'b0, c, r.vec ? 2'(i) : 2'd0, i == r.beats - 1, r.ill));
    end
  endtask

  typedef struct {
    logic        v;
    logic [10:0] op;
    logic        fl;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[17];

  task automatic do_reset();
    reset = 1'b1; instr_valid = 1'b0; flush = 1'b0; instruction = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [10:0] pick_ops[14];

  initial begin
    logic [14:0] exp;
    logic        rdy;
    logic [10:0] op;

    tbl[0]  = '{1'b1, OP_ADD,  1'b0, e(0, 1, C_NONE, 0, 0, 0)};
    tbl[1]  = '{1'b1, OP_VLD1, 1'b0, e(1, 1, C_ALU,  0, 1, 0)};
    tbl[2]  = '{1'b1, OP_SUB,  1'b0, e(1, 0, C_VLD1, 0, 0, 0)};
    tbl[3]  = '{1'b1, OP_SUB,  1'b0, e(1, 0, C_VLD1, 1, 0, 0)};
    tbl[4]  = '{1'b1, OP_SUB,  1'b0, e(1, 0, C_VLD1, 2, 0, 0)};
    tbl[5]  = '{1'b1, OP_SUB,  1'b0, e(1, 1, C_VLD1, 3, 1, 0)};
    tbl[6]  = '{1'b1, OP_MUL,  1'b0, e(1, 1, C_ALU,  0, 1, 0)};
    tbl[7]  = '{1'b0, OP_ADD,  1'b0, e(1, 0, C_MULW, 0, 0, 0)};
    tbl[8]  = '{1'b0, OP_ADD,  1'b0, e(1, 0, C_MULW, 0, 0, 0)};
    tbl[9]  = '{1'b1, 11'd0,   1'b0, e(1, 1, C_ALU,  0, 1, 0)};
    tbl[10] = '{1'b1, OP_CBZ,  1'b0, e(1, 1, C_NONE, 0, 1, 1)};
    tbl[11] = '{1'b1, OP_VADD, 1'b0, e(1, 1, C_CBZ,  0, 1, 0)};
    tbl[12] = '{1'b1, OP_ADD,  1'b0, e(1, 0, C_ALU,  0, 0, 0)};
    tbl[13] = '{1'b1, OP_ADD,  1'b1, e(1, 0, C_ALU,  1, 0, 0)};
    tbl[14] = '{1'b1, OP_ADD,  1'b0, e(0, 1, C_NONE, 0, 0, 0)};
    tbl[15] = '{1'b0, OP_ADD,  1'b0, e(1, 1, C_ALU,  0, 1, 0)};
    tbl[16] = '{1'b0, OP_ADD,  1'b0, e(0, 1, C_NONE, 0, 0, 0)};

    pick_ops = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_MUL, OP_VADD,
                 OP_VSUB, OP_VMUL, OP_VMOV, OP_VST1, OP_VLD1, OP_CBZ};

    // Directed cycle table: inputs driven on the falling edge, outputs checked 1 ns later.
    reset = 1'b1; instr_valid = 1'b0; flush = 1'b0; instruction = '0;
    #1;
    check("reset_state", observe(), e(0, 1, C_NONE, 0, 0, 0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      instr_valid = tbl[i].v;
      flush       = tbl[i].fl;
      instruction = {tbl[i].op, 21'($urandom)};
      #1;
      check($sformatf("table[%0d]", i), observe(), tbl[i].exp);
      @(negedge clk);
    end

    // Async reset during MUL beat 1, asserted between edges.
    instr_valid = 1'b1; instruction = {OP_MUL, 21'h0};
    @(posedge clk); #1;
    instr_valid = 1'b0; instruction = {OP_VLD1, 21'h0};
    @(posedge clk); #1;
    check("mul_beat1", observe(), e(1, 0, C_MULW, 0, 0, 0));
    #2 reset = 1'b1;
    #1;
    check("async_reset", observe() & 15'h5FFF, 15'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset", observe(), e(0, 1, C_NONE, 0, 0, 0));
    @(negedge clk); #1;
    check("no_residual", observe(), e(0, 1, C_NONE, 0, 0, 0));

    // Random traffic against the beat-queue model.
    do_reset();
    beat_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      instr_valid = ($urandom_range(3) != 0);
      flush       = ($urandom_range(15) == 0);
      if ($urandom_range(7) == 0)      op = 11'($urandom);
      else if ($urandom_range(9) == 0) op = {6'b000101, 5'($urandom)};
      else                              op = pick_ops[$urandom_range(13)];
      instruction = {op, 21'($urandom)};
      #1;
      rdy = (beat_q.size() <= 1) && !flush;
      exp = (beat_q.size() != 0) ? beat_q[0] : 15'h0;
      exp[13] = rdy;
      check($sformatf("random cyc %0d op %b", cyc, op), observe(), exp);
      if (beat_q.size() != 0) void'(beat_q.pop_front());
      if (flush) beat_q.delete();
      else if (instr_valid && rdy) push_beats(op);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
